// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
// Module   : ps2_keyboard_rx
// Brief    : PS/2 device-to-host receiver with scan-code FIFO and level IRQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    input  logic                            rd_en,
    input  logic                            err_clr,
    output logic [7:0]                      rd_data,
    output logic                            rd_valid,
    output logic                            irq,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            perr,
    output logic                            ferr,
    output logic                            ovf
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_fcnt;
    logic          w_fall;

    state_t        r_state;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tcnt;
    logic          r_push;
    logic [7:0]    r_push_byte;
    logic          r_perr, r_ferr, r_ovf;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop, w_full, w_wr;

    // Synchronisers idle high so reset never looks like a falling clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + FW'(1);
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_tcnt      <= '0;
            r_push      <= 1'b0;
            r_push_byte <= '0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_push <= 1'b0;
            r_perr <= r_perr & ~err_clr;
            r_ferr <= r_ferr & ~err_clr;

            if (r_state == S_IDLE || w_fall) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TW'(1);
            end

            if (r_state != S_IDLE && !w_fall && r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_state <= S_IDLE;
                r_ferr  <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state <= S_DATA;
                            r_bit   <= '0;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= S_STOP;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        if (!r_dat_s2) begin
                            r_ferr <= 1'b1;
                        end
                        if (!(^{r_shift, r_par})) begin
                            r_perr <= 1'b1;
                        end
                        if (r_dat_s2 && (^{r_shift, r_par})) begin
                            r_push      <= 1'b1;
                            r_push_byte <= r_shift;
                        end
                    end
                endcase
            end
        end
    end

    // A pop frees the slot being written, so a full FIFO still accepts a byte.
    assign w_pop  = rd_en && (r_count != '0);
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_wr   = r_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_push_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~err_clr) | (r_push & w_full & ~w_pop);
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_valid = (r_count != '0);
    assign irq      = rd_valid;
    assign rd_data  = rd_valid ? r_mem[r_rptr] : 8'h00;
    assign count    = r_count;
    assign perr     = r_perr;
    assign ferr     = r_ferr;
    assign ovf      = r_ovf;

endmodule

`default_nettype wire
